// File: rtl/fp32_addtree_normalize_pkg.sv
// Shared FP32 constants and default widths for the adder-tree normalize stage.
// Latency: n/a (constants only).
// Backpressure: n/a.
package fp32_addtree_normalize_pkg;

  localparam int          FP32_BIAS      = 127;
  localparam int          FP32_EXP_INF   = 2 * FP32_BIAS + 1;
  localparam logic [31:0] FP32_QNAN      = 32'h7FC00000;
  localparam logic [31:0] FP32_PINF      = 32'h7F800000;
  localparam logic [31:0] FP32_NINF      = 32'hFF800000;
  localparam int          FRAC_BITS_DEF  = 26;
  localparam int          FULL_SUM_WIDTH = 30;

endpackage

// File: rtl/fp32_addtree_normalize_lzc.sv
// Combinational leading-zero counter with all-zero flag.
// Latency: 0 cycles (pure combinational).
// Backpressure: n/a.
module fp32_lzc #(
  parameter int W  = 32,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  din,
  output logic [CW-1:0] cnt,
  output logic          all_zero
);

  // Scan upward so the highest set bit is the last (winning) assignment.
  always_comb begin
    cnt = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (din[i]) cnt = CW'(W - 1 - i);
    end
    all_zero = (din == '0);
  end

endmodule

// File: rtl/fp32_addtree_normalize.sv
// Normalize, round-to-nearest-even and pack the tree sum into one FP32 result.
// Latency: 3 cycles from input transfer to out_valid; 1 result per cycle.
// Backpressure: per-stage valid/ready, empty stages fill without waiting for out_ready.
module fp32_addtree_normalize
  import fp32_addtree_normalize_pkg::*;
#(
  parameter int WIDTH     = FULL_SUM_WIDTH,
  parameter int FRAC_BITS = FRAC_BITS_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH+1:0] in_sum,
  input  logic [7:0]       in_exp_max,
  input  logic             in_nan,
  input  logic             in_pinf,
  input  logic             in_ninf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result
);

  localparam int SW = WIDTH + 2;
  localparam int CW = $clog2(SW + 1);
  localparam logic signed [9:0] EXP_INF_S = 10'(FP32_EXP_INF);

  logic v1, v2, v3;
  logic load1, load2, load3;

  // Stage 1 registers: sign/magnitude split
  logic          s1_sign;
  logic [SW-1:0] s1_mag;
  logic [7:0]    s1_exp;
  logic          s1_nan, s1_pinf, s1_ninf;

  // Stage 2 registers: normalized magnitude
  logic               s2_sign;
  logic [SW-1:0]      s2_norm;
  logic signed [9:0]  s2_exp;
  logic               s2_zero;
  logic               s2_nan, s2_pinf, s2_ninf;

  assign load3     = ~v3 | out_ready;
  assign load2     = ~v2 | load3;
  assign load1     = ~v1 | load2;
  assign in_ready  = load1;
  assign out_valid = v3;

  // Valid bits advance every cycle; a non-loading stage keeps its beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else begin
      if (load1) v1 <= in_valid;
      if (load2) v2 <= v1;
      if (load3) v3 <= v2;
    end
  end

  // S1: absolute value; SW-bit unsigned negate keeps the most negative sum exact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_sign <= 1'b0;
      s1_mag  <= '0;
      s1_exp  <= '0;
      s1_nan  <= 1'b0;
      s1_pinf <= 1'b0;
      s1_ninf <= 1'b0;
    end else if (load1) begin
      s1_sign <= in_sum[SW-1];
      s1_mag  <= in_sum[SW-1] ? (~in_sum + 1'b1) : in_sum;
      s1_exp  <= in_exp_max;
      s1_nan  <= in_nan;
      s1_pinf <= in_pinf;
      s1_ninf <= in_ninf;
    end
  end

  logic [CW-1:0] lz;
  logic          mag_zero;

  fp32_lzc #(.W(SW)) u_lzc (
    .din      (s1_mag),
    .cnt      (lz),
    .all_zero (mag_zero)
  );

  // S2: shift MSB to the top; exponent = exp_max + (SW-1-lz) - FRAC_BITS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_sign <= 1'b0;
      s2_norm <= '0;
      s2_exp  <= '0;
      s2_zero <= 1'b0;
      s2_nan  <= 1'b0;
      s2_pinf <= 1'b0;
      s2_ninf <= 1'b0;
    end else if (load2) begin
      s2_sign <= s1_sign;
      s2_norm <= s1_mag << lz;
      s2_exp  <= $signed({2'b00, s1_exp} + 10'(SW - 1 - FRAC_BITS) - 10'(lz));
      s2_zero <= mag_zero;
      s2_nan  <= s1_nan;
      s2_pinf <= s1_pinf;
      s2_ninf <= s1_ninf;
    end
  end

  logic              guard, sticky, lsb, round_up, carry;
  logic [22:0]       frac;
  logic signed [9:0] exp_fin;
  logic [31:0]       result;

  // S3: round to nearest even, then apply special/overflow/underflow priority.
  always_comb begin
    lsb      = s2_norm[SW-24];
    guard    = s2_norm[SW-25];
    sticky   = |s2_norm[SW-26:0];
    round_up = guard & (sticky | lsb);
    carry    = round_up & (&s2_norm[SW-1 -: 24]);
    // All-ones mantissa wraps the fraction to zero, which is the carry case.
    frac     = s2_norm[SW-2 -: 23] + 23'(round_up);
    exp_fin  = carry ? (s2_exp + 10'sd1) : s2_exp;
    if (s2_nan || (s2_pinf && s2_ninf)) result = FP32_QNAN;
    else if (s2_pinf)                   result = FP32_PINF;
    else if (s2_ninf)                   result = FP32_NINF;
    else if (s2_zero)                   result = 32'h0;
    else if (exp_fin >= EXP_INF_S)      result = {s2_sign, 8'hFF, 23'd0};
    else if (exp_fin <= 10'sd0)         result = {s2_sign, 31'd0};
    else                                result = {s2_sign, exp_fin[7:0], frac};
  end

  // Output register holds while downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_result <= 32'h0;
    else if (load3 && v2) out_result <= result;
  end

endmodule
